button_pulse_gen: RTL and testbench

- Front end for the game logic FSM's `up`, `down`, `left`, `right` and `center` inputs.
- Takes the five raw, asynchronous board pushbuttons and processes each one independently:
  - synchronises it;
  - debounces it;
  - emits single-cycle press pulses.
- Directional buttons also auto-repeat while held, so the cursor keeps stepping. `center` never repeats, so at most one stone is placed per press.

---
 rtl/button_pulse_gen.sv | 120 ++++++++++++
 tb/tb_button_pulse_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// Five-channel pushbutton front end. Each button is synchronised and debounced,
// and each new press becomes a one-cycle pulse. Masked buttons also auto-repeat while held.
module button_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 15000000,
  parameter logic [4:0]  REPEAT_MASK     = 5'b01111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       center,
  output logic [4:0] held
);

  localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  DELAY_LOAD  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0]  PERIOD_LOAD = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REPEAT, HELD} state_e;

  logic [4:0] pulse;

  for (genvar b = 0; b < 5; b++) begin : g_btn
    logic           sync1_q, sync2_q;
    logic [DBW-1:0] dbCnt_q, dbCnt_d;
    logic           stable_q, stable_d;
    logic           stableRise;
    state_e         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           pulse_q, pulse_d;

    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
      end
    end

    // Accept a new level only after it has disagreed with stable for DEBOUNCE_CYCLES edges.
    always_comb begin
      dbCnt_d  = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
        if (dbCnt_q == DB_LAST) begin
          stable_d = sync2_q;
        end else begin
          dbCnt_d = dbCnt_q + 1'b1;
        end
      end
    end

    // The FSM acts on the debounced level of this very edge so the press pulse
    // lines up with the rise of held.
    assign stableRise = stable_d & ~stable_q;

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (stableRise) begin
            pulse_d = 1'b1;
            hold_d  = DELAY_LOAD;
            state_d = REPEAT_MASK[b] ? WAIT : HELD;
          end
        end
        WAIT, REPEAT: begin
          if (!stable_d) begin
            state_d = IDLE;
          end else if (hold_q == '0) begin
            pulse_d = 1'b1;
            hold_d  = PERIOD_LOAD;
            state_d = REPEAT;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        HELD: begin
          if (!stable_d) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        dbCnt_q  <= '0;
        stable_q <= 1'b0;
        state_q  <= IDLE;
        hold_q   <= '0;
        pulse_q  <= 1'b0;
      end else begin
        dbCnt_q  <= dbCnt_d;
        stable_q <= stable_d;
        state_q  <= state_d;
        hold_q   <= hold_d;
        pulse_q  <= pulse_d;
      end
    end

    assign held[b]  = stable_q;
    assign pulse[b] = pulse_q;
  end

  assign {center, up, down, left, right} = pulse;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios with literal expectations plus
// randomized button activity, all checked every cycle against a window-based model.
module tb_button_pulse_gen;

  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [4:0] MASK = 5'b01111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic       up, down, left, right, center;
  logic [4:0] held;
  logic [4:0] pulseVec;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state: raw sample history (index 0 = newest), last debounce change and last rise per button.
  int         edgeNo = 0;
  logic [4:0] expStable = '0;
  logic [4:0] expPulse = '0;
  int         lastChange [5];
  int         riseEdge [5];
  logic [4:0] rawHist [16];

  int rightEdges [11] = '{5, 15, 18, 21, 24, 27, 30, 33, 36, 39, 42};

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .center(center),
    .held(held)
  );

  assign pulseVec = {center, up, down, left, right};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  // A level is accepted once the synchronised input (raw delayed two edges) has
  // differed from the accepted level on the last DB edges with no change in between.
  task automatic modelStep();
    bit   allDiff;
    logic newStable;
    int   d;
    edgeNo++;
    if (!rst) begin
      for (int i = 0; i < 16; i++) rawHist[i] = '0;
      expStable = '0;
      expPulse  = '0;
      for (int b = 0; b < 5; b++) begin
        lastChange[b] = edgeNo;
        riseEdge[b]   = -1000;
      end
    end else begin
      for (int b = 0; b < 5; b++) begin
        newStable = expStable[b];
        if (edgeNo - lastChange[b] >= DB) begin
          allDiff = 1'b1;
          for (int i = 0; i < DB; i++) begin
            if (rawHist[i+1][b] == expStable[b]) allDiff = 1'b0;
          end
          if (allDiff) begin
            newStable     = ~expStable[b];
            lastChange[b] = edgeNo;
            if (newStable) riseEdge[b] = edgeNo;
          end
        end
        expStable[b] = newStable;
        d = edgeNo - riseEdge[b];
        expPulse[b] = newStable && (d == 0 ||
                      (MASK[b] && (d == RD || (d > RD && ((d - RD) % RP) == 0))));
      end
      for (int i = 15; i > 0; i--) rawHist[i] = rawHist[i-1];
      rawHist[0] = btn_raw;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("heldVsModel", held, expStable);
        checkOutput("pulseVsModel", pulseVec, expPulse);
      end
    end
  end

  // Drive inputs just after a falling edge, then let n rising edges pass.
  task automatic applyStimulus(input logic r, input logic [4:0] b, input int n);
    rst     = r;
    btn_raw = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic       bouncePat [7];
    logic       anyUp;
    logic       expBit;
    logic [4:0] rb;

    rst     = 1'b0;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetHeld", held, 5'b00000);
    checkOutput("resetPulse", pulseVec, 5'b00000);
    applyStimulus(1'b1, 5'b00000, 50);
    checkOutput("idleHeld", held, 5'b00000);
    checkOutput("idlePulse", pulseVec, 5'b00000);

    // Clean center press: one pulse five edges after first sample, never repeats.
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 5'b10000, 1);
      expBit = (i == 6);
      checkOutput("centerPulse", {4'b0, center}, {4'b0, expBit});
      if (i == 5) checkOutput("centerHeldBefore", {4'b0, held[4]}, 5'b00000);
      if (i == 6) begin
        checkOutput("centerHeldAt", {4'b0, held[4]}, 5'b00001);
        checkOutput("modelCenterPin", {4'b0, expPulse[4]}, 5'b00001);
      end
    end
    applyStimulus(1'b1, 5'b00000, 10);
    checkOutput("centerReleased", held, 5'b00000);

    // Bounce on up: no run long enough to be accepted.
    bouncePat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    anyUp = 1'b0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, {1'b0, bouncePat[i], 3'b000}, 1);
      anyUp = anyUp | up | held[3];
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'b00000, 1);
      anyUp = anyUp | up | held[3];
    end
    checkOutput("bounceUp", {4'b0, anyUp}, 5'b00000);

    // Auto-repeat on right, then release; the pulse due as stable falls is suppressed.
    for (int i = 1; i <= 52; i++) begin
      applyStimulus(1'b1, (i <= 40) ? 5'b00001 : 5'b00000, 1);
      expBit = 1'b0;
      foreach (rightEdges[j]) if (rightEdges[j] == i - 1) expBit = 1'b1;
      checkOutput("rightPulse", {4'b0, right}, {4'b0, expBit});
      checkOutput("modelRightPin", {4'b0, expPulse[0]}, {4'b0, expBit});
      expBit = (i - 1 >= 5) && (i - 1 <= 44);
      checkOutput("rightHeld", {4'b0, held[0]}, {4'b0, expBit});
    end
    applyStimulus(1'b1, 5'b00000, 5);

    // Simultaneous left+down, reset during WAIT, fresh press after reset release.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 5'b00110, 1);
      if (i == 6) checkOutput("dualPress", pulseVec, 5'b00110);
    end
    applyStimulus(1'b0, 5'b00110, 2);
    checkOutput("midResetHeld", held, 5'b00000);
    checkOutput("midResetPulse", pulseVec, 5'b00000);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 5'b00110, 1);
      if (i == 5) checkOutput("postResetEarly", pulseVec, 5'b00000);
      if (i == 6) checkOutput("postResetPress", pulseVec, 5'b00110);
      if (i == 7) checkOutput("postResetAfter", pulseVec, 5'b00000);
    end
    applyStimulus(1'b1, 5'b00000, 10);

    // Random activity with occasional resets, checked by the per-cycle model compare.
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 99) < 7) rb[b] = ~rb[b];
      end
      applyStimulus(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rb, 1);
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
